sr_pulse_driver: RTL and testbench
==================================

SR_PULSE_DRIVER -- requirements
Module: sr_pulse_driver

Interface
REQ-001 Parameter DB_CYCLES, default 16, consecutive stable samples required to accept a new synchronized button level; legal range 1..65535.
REQ-002 Parameter PULSE_CYCLES, default 4, width in clocks of each S or R pulse; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 btn_set  input  1  raw asynchronous set button, bounce permitted.
REQ-006 btn_reset  input  1  raw asynchronous reset button, bounce permitted.
REQ-007 clr_conflict  input  1  synchronous clear for the conflict flag.
REQ-008 S  output  1  registered set pulse to the downstream SR NOR latch S input.
REQ-009 R  output  1  registered reset pulse to the downstream SR NOR latch R input.
REQ-010 busy  output  1  high while the FSM is in any state other than IDLE.
REQ-011 conflict  output  1  sticky flag: simultaneous set and reset requests were detected.

Function
REQ-012 Each button passes through its own two-flop synchronizer before any other logic uses it.
REQ-013 Each channel holds a debounced level and a counter sized $clog2(DB_CYCLES+1).
  - Counter clears whenever sync output equals the debounced level.
  - Otherwise the counter increments.
  - On the edge where the counter reaches DB_CYCLES, the debounced level toggles and the counter clears.
REQ-014 A 0->1 transition of a debounced level is a request; a 1->0 transition produces no request.
REQ-015 The FSM has four states:
  - IDLE: S=0, R=0.
  - SET_P: S=1, R=0.
  - RST_P: S=0, R=1.
  - GAP: S=0, R=0.
REQ-016 IDLE transitions:
  - Set request only -> SET_P.
  - Reset request only -> RST_P.
  - Both in the same cycle -> stay in IDLE, drop both requests, set conflict.
REQ-017 SET_P and RST_P each last exactly PULSE_CYCLES clocks, then transition to GAP.
REQ-018 GAP lasts exactly 1 clock, then transitions:
  - Set pending -> SET_P.
  - Else reset pending -> RST_P.
  - Else -> IDLE.
REQ-019 A request arriving in SET_P, RST_P or GAP sets that channel's pending bit, a one-deep queue.
  - Repeat requests while the bit is already set are absorbed.
  - A pending bit clears when its pulse starts.
REQ-020 If set and reset pending are both set at GAP exit, the FSM serves set first and reset after the next GAP.
REQ-021 S and R are never high in the same cycle under any input sequence.
REQ-022 Latency: btn_set rises and stays high while the FSM is in IDLE -> S is first high on the (DB_CYCLES+4)th rising edge after the first edge that samples the change. Same latency applies to btn_reset and R.
REQ-023 conflict stays at 1 until a clock edge with clr_conflict=1.
  - If a new conflict occurs on the same edge as clr_conflict, conflict remains 1 (set wins).
REQ-024 The pulse counter is sized $clog2(PULSE_CYCLES+1) and holds no state outside SET_P and RST_P.

Reset
REQ-025 While rst_n=0, asynchronously:
  - S=0, R=0, busy=0, conflict=0.
  - FSM=IDLE.
  - Synchronizers, debounced levels, counters and pending bits = 0.
REQ-026 If rst_n is asserted during a pulse, the pulse is truncated immediately, and nothing is replayed after release.
REQ-027 A button already high at reset release produces a request DB_CYCLES+3 edges later, because the debounced level starts at 0.

Verification (DB_CYCLES=4, PULSE_CYCLES=3)
REQ-028 Clean press: btn_set 0->1, held -> S=1 on edges 8..10, busy=1 edges 8..11, R=0 throughout, conflict=0.
REQ-029 Bounce: btn_set toggles every 2 clocks for 12 clocks, then holds 1 -> exactly one S pulse of 3 clocks, starting 8 edges after the final transition.
REQ-030 Simultaneous press: btn_set and btn_reset rise on the same cycle -> no S or R pulse, conflict=1. Then clr_conflict for 1 clock -> conflict=0.
REQ-031 Queued request: btn_reset is debounced during an active S pulse -> S lasts 3 clocks, one GAP clock follows, then R for 3 clocks. S&R=0 on every cycle.
REQ-032 Reset mid-pulse: rst_n=0 on the 2nd S cycle -> S=0 in the same cycle without waiting for a clock. After release with buttons at 0, no output pulses occur.

Source files
------------

// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: debounced set/reset buttons to non-overlapping S/R pulses for an SR NOR latch
// Each channel has a one-deep pending queue; simultaneous requests from IDLE raise a sticky conflict flag.
module sr_pulse_driver #(
   parameter int DB_CYCLES    = 16,
   parameter int PULSE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_set,
   input  logic btn_reset,
   input  logic clr_conflict,
   output logic S,
   output logic R,
   output logic busy,
   output logic conflict
);
   localparam int DW = $clog2(DB_CYCLES + 1);
   localparam int PW = $clog2(PULSE_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
   localparam logic [PW-1:0] P_LAST  = PW'(PULSE_CYCLES);
   localparam logic [PW-1:0] P_FIRST = PW'(1);
   typedef enum logic [1:0] {IDLE, SET_P, RST_P, GAP} state_t;
   state_t        state;
   logic [1:0]    sync1, sync2, db, db_d, req, pend, eff;
   logic [DW-1:0] cnt [2];
   logic [PW-1:0] pcnt;
   // bit 0 is the set channel, bit 1 the reset channel
   assign eff = pend | req;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync1  <= '0;
         sync2  <= '0;
         db     <= '0;
         db_d   <= '0;
         req    <= '0;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         sync1 <= {btn_reset, btn_set};
         sync2 <= sync1;
         db_d  <= db;
         req   <= db & ~db_d;
         for (int i = 0; i < 2; i++)
            if (sync2[i] == db[i])
               cnt[i] <= '0;
            else if (cnt[i] == DB_LAST) begin
               cnt[i] <= '0;
               db[i]  <= ~db[i];
            end else
               cnt[i] <= cnt[i] + 1'b1;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         S        <= 1'b0;
         R        <= 1'b0;
         busy     <= 1'b0;
         conflict <= 1'b0;
         pend     <= '0;
         pcnt     <= '0;
      end else begin
         conflict <= (state == IDLE && req == 2'b11) || (conflict && !clr_conflict);
         case (state)
            IDLE:
               if (req == 2'b01) begin
                  state <= SET_P;
                  S     <= 1'b1;
                  busy  <= 1'b1;
                  pcnt  <= P_FIRST;
               end else if (req == 2'b10) begin
                  state <= RST_P;
                  R     <= 1'b1;
                  busy  <= 1'b1;
                  pcnt  <= P_FIRST;
               end
            SET_P, RST_P: begin
               pend <= eff;
               if (pcnt == P_LAST) begin
                  state <= GAP;
                  S     <= 1'b0;
                  R     <= 1'b0;
                  pcnt  <= '0;
               end else
                  pcnt <= pcnt + 1'b1;
            end
            default:
               // GAP: set is served ahead of reset when both are waiting
               if (eff[0]) begin
                  state <= SET_P;
                  S     <= 1'b1;
                  pcnt  <= P_FIRST;
                  pend  <= {eff[1], 1'b0};
               end else if (eff[1]) begin
                  state <= RST_P;
                  R     <= 1'b1;
                  pcnt  <= P_FIRST;
                  pend  <= '0;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
         endcase
      end
endmodule

// File: tb/tb_sr_pulse_driver.sv
// tb_sr_pulse_driver: table vectors, corner-case sequences and random buttons vs a scheduling model
module tb_sr_pulse_driver;
   localparam int DB = 4;
   localparam int PC = 3;
   logic clk = 1'b0, rst_n = 1'b0, btn_set = 1'b0, btn_reset = 1'b0, clr_conflict = 1'b0;
   logic S, R, busy, conflict;
   sr_pulse_driver #(.DB_CYCLES(DB), .PULSE_CYCLES(PC)) dut (
      .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_reset(btn_reset),
      .clr_conflict(clr_conflict), .S(S), .R(R), .busy(busy), .conflict(conflict)
   );
   always #5 clk = ~clk;
   typedef struct {
      bit       bs;
      bit       br;
      bit       clr;
      int       n;
      bit [3:0] exp;
   } vec_t;
   vec_t tbl[$];
   int n_vec = 0, n_bad = 0;
   // model: edge count since reset, edge at which the machine next decides, current pulse start
   int e, decide_at, start;
   bit kind_s, conf_m;
   bit [1:0] db_m, rise1, rise2, pend_m;
   bit [DB:0] hist [2];
   bit [3:0] exp_m;
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      e = 0; decide_at = 0; start = -1000; kind_s = 0; conf_m = 0;
      db_m = '0; rise1 = '0; rise2 = '0; pend_m = '0; hist[0] = '0; hist[1] = '0; exp_m = '0;
   endtask
   task automatic model_step();
      bit [1:0] rq, btn, eff;
      bit cevt, all_diff, on;
      if (!rst_n) begin
         model_reset();
         return;
      end
      e++;
      rq = rise2; rise2 = rise1; rise1 = '0;
      btn = {btn_reset, btn_set};
      for (int c = 0; c < 2; c++) begin
         all_diff = 1;
         for (int k = 1; k <= DB; k++) if (hist[c][k] == db_m[c]) all_diff = 0;
         if (all_diff) begin
            rise1[c] = !db_m[c];
            db_m[c] = !db_m[c];
         end
         hist[c] = {hist[c][DB-1:0], btn[c]};
      end
      cevt = 0;
      eff = pend_m | rq;
      if (e < decide_at) pend_m = eff;
      else if (e > decide_at && rq == 2'b11) cevt = 1;
      else if (eff[0]) begin
         start = e; kind_s = 1; decide_at = e + PC + 1; pend_m = {eff[1], 1'b0};
      end else if (eff[1]) begin
         start = e; kind_s = 0; decide_at = e + PC + 1; pend_m = '0;
      end
      conf_m = cevt || (conf_m && !clr_conflict);
      on = e >= start && e < start + PC;
      exp_m = {kind_s && on, !kind_s && on, e < decide_at, conf_m};
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         check("model", {S, R, busy, conflict}, exp_m);
         check("s_and_r", S & R, 0);
      end
   endtask
   initial begin
      #5_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
   initial begin
      logic [31:0] sbits, rbits;
      int first, cnt, hits;
      tbl.push_back('{1, 0, 0, 7, 4'b0000});
      tbl.push_back('{1, 0, 0, 1, 4'b1010});
      tbl.push_back('{1, 0, 0, 2, 4'b1010});
      tbl.push_back('{1, 0, 0, 1, 4'b0010});
      tbl.push_back('{1, 0, 0, 1, 4'b0000});
      tbl.push_back('{0, 0, 0, 10, 4'b0000});
      tbl.push_back('{0, 1, 0, 8, 4'b0110});
      tbl.push_back('{0, 1, 0, 3, 4'b0010});
      tbl.push_back('{0, 1, 0, 1, 4'b0000});
      tbl.push_back('{0, 0, 0, 10, 4'b0000});
      tbl.push_back('{1, 1, 0, 7, 4'b0000});
      tbl.push_back('{1, 1, 0, 1, 4'b0001});
      tbl.push_back('{1, 1, 0, 5, 4'b0001});
      tbl.push_back('{1, 1, 1, 1, 4'b0000});
      tbl.push_back('{0, 0, 0, 10, 4'b0000});
      tbl.push_back('{1, 1, 0, 7, 4'b0000});
      tbl.push_back('{1, 1, 1, 1, 4'b0001});
      tbl.push_back('{1, 1, 0, 1, 4'b0001});
      tbl.push_back('{0, 0, 1, 1, 4'b0000});
      tbl.push_back('{0, 0, 0, 10, 4'b0000});
      model_reset();
      #12;
      check("reset", {S, R, busy, conflict}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      foreach (tbl[i]) begin
         btn_set = tbl[i].bs;
         btn_reset = tbl[i].br;
         clr_conflict = tbl[i].clr;
         tick(tbl[i].n);
         check($sformatf("vec%0d", i), {S, R, busy, conflict}, tbl[i].exp);
      end
      clr_conflict = 1'b0;
      // reset request debounced while S is active
      btn_set = 1'b1;
      tick(1);
      btn_reset = 1'b1;
      sbits = '0;
      rbits = '0;
      for (int k = 2; k <= 20; k++) begin
         tick(1);
         sbits[k] = S;
         rbits[k] = R;
      end
      check("queued_s", sbits, 32'h0000_0700);
      check("queued_r", rbits, 32'h0000_7000);
      btn_set = 1'b0;
      btn_reset = 1'b0;
      tick(12);
      // bouncing set button
      for (int k = 0; k < 12; k++) begin
         btn_set = (k % 4) < 2;
         tick(1);
      end
      btn_set = 1'b1;
      first = 0;
      cnt = 0;
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         if (S) begin
            cnt++;
            if (first == 0) first = k;
         end
      end
      check("bounce_first", first, 8);
      check("bounce_width", cnt, 3);
      btn_set = 1'b0;
      tick(12);
      // button already high when reset is released
      rst_n = 1'b0;
      btn_set = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(7);
      check("release_pre", S, 0);
      tick(1);
      check("release_s", S, 1);
      tick(6);
      btn_set = 1'b0;
      tick(12);
      // asynchronous reset on the second S cycle
      btn_set = 1'b1;
      tick(9);
      check("mid_s_on", S, 1);
      #2 rst_n = 1'b0;
      #1 check("mid_async", {S, R, busy, conflict}, 0);
      model_reset();
      btn_set = 1'b0;
      tick(2);
      rst_n = 1'b1;
      hits = 0;
      for (int k = 0; k < 20; k++) begin
         tick(1);
         hits += int'(S | R);
      end
      check("mid_replay", hits, 0);
      // random buttons and clears
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 11) == 0) btn_set = !btn_set;
         if ($urandom_range(0, 11) == 0) btn_reset = !btn_reset;
         clr_conflict = $urandom_range(0, 19) == 0;
         tick(1);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
